instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 195 +++++++++++++++++++
 tb/tb_instr_encoder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Batch encoder: packs RV32 instruction fields into 32-bit words, one accepted
// entry per cycle, and tags each emitted word with a sequential write address.
module instr_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [15:0] count,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  fmt,
    input  logic [31:0] imm,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [6:0]  opcode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        busy,
    output logic        done,
    output logic [7:0]  err_count
);

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned INSTR_W   = 32;
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned ERR_W     = 8;
    localparam int unsigned ADDR_STEP = 4;

    localparam logic [2:0] FMT_I = 3'b000;
    localparam logic [2:0] FMT_S = 3'b001;
    localparam logic [2:0] FMT_B = 3'b010;
    localparam logic [2:0] FMT_U = 3'b011;
    localparam logic [2:0] FMT_J = 3'b100;
    localparam logic [2:0] FMT_R = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [CNT_W-1:0]    r_remain;
    logic [ERR_W-1:0]    r_err;
    logic                r_out_valid;
    logic [INSTR_W-1:0]  r_out_instr;

    logic                w_in_ready;
    logic                w_done;
    logic                w_busy;
    logic                w_start_take;
    logic                w_accept;
    logic                w_out_hs;
    logic                w_last;
    logic [INSTR_W-1:0]  w_instr;
    logic                w_err;
    logic                w_fits12;
    logic                w_fits13;
    logic                w_fits21;

    // Immediate range checks: the value fits if all bits above the field's sign bit match it
    assign w_fits12 = (imm[31:11] == '0) || (imm[31:11] == '1);
    assign w_fits13 = (imm[31:12] == '0) || (imm[31:12] == '1);
    assign w_fits21 = (imm[31:20] == '0) || (imm[31:20] == '1);

    // Field packing and error classification per format
    always_comb begin
        w_instr = '0;
        w_err   = 1'b0;
        case (fmt)
            FMT_I: begin
                w_instr = {imm[11:0], rs1, funct3, rd, opcode};
                w_err   = !w_fits12;
            end
            FMT_S: begin
                w_instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                w_err   = !w_fits12;
            end
            FMT_B: begin
                w_instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                w_err   = !w_fits13 || imm[0];
            end
            FMT_U: begin
                w_instr = {imm[31:12], rd, opcode};
                w_err   = (imm[11:0] != 12'd0);
            end
            FMT_J: begin
                w_instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                w_err   = !w_fits21 || imm[0];
            end
            FMT_R: begin
                w_instr = {funct7, rs2, rs1, funct3, rd, opcode};
                w_err   = 1'b0;
            end
            default: begin
                w_instr = '0;
                w_err   = 1'b1;
            end
        endcase
    end

    assign w_start_take = start && (r_state == S_IDLE);
    assign w_accept     = in_valid && w_in_ready;
    assign w_out_hs     = r_out_valid && out_ready;
    assign w_last       = (r_remain == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and handshake/status decode
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_done      = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (start) begin
                    w_state_nxt = (count == CNT_W'(0)) ? S_DRAIN : S_RUN;
                end
            end
            S_RUN: begin
                w_in_ready = !r_out_valid || out_ready;
                if (in_valid && w_in_ready && w_last) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!r_out_valid) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Batch counters and the output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_remain    <= '0;
            r_err       <= '0;
            r_out_valid <= 1'b0;
            r_out_instr <= '0;
        end else begin
            if (w_start_take) begin
                r_addr   <= base_addr;
                r_remain <= count;
                r_err    <= '0;
            end else begin
                if (w_out_hs) begin
                    r_addr <= r_addr + ADDR_W'(ADDR_STEP);
                end
                if (w_accept) begin
                    r_remain <= r_remain - CNT_W'(1);
                end
                if (w_accept && w_err && (r_err != '1)) begin
                    r_err <= r_err + ERR_W'(1);
                end
            end
            // A fresh entry overwrites the slot being drained in the same cycle
            if (w_accept && !w_err) begin
                r_out_valid <= 1'b1;
                r_out_instr <= w_instr;
            end else if (w_out_hs) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign busy      = w_busy;
    assign done      = w_done;
    assign out_valid = r_out_valid;
    assign out_instr = r_out_instr;
    assign out_addr  = r_addr;
    assign err_count = r_err;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with hand-computed encodings and addresses.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] count;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  fmt;
    logic [31:0] imm;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7, opcode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr, out_addr;
    logic        busy, done;
    logic [7:0]  err_count;

    int checks   = 0;
    int failures = 0;
    int acc_cnt  = 0;
    int done_cnt = 0;
    logic [63:0] outq[$];

    instr_encoder dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
        .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt), .imm(imm),
        .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7), .opcode(opcode),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
        .busy(busy), .done(done), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Record output handshakes, input acceptances and done pulses
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) outq.push_back({out_addr, out_instr});
        if (rst_n && in_valid && in_ready) acc_cnt++;
        if (rst_n && done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [31:0] b, input logic [15:0] c);
        base_addr = b;
        count     = c;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic set_entry(input logic [2:0] f, input logic [31:0] im, input logic [4:0] d,
                             input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                             input logic [6:0] f7, input logic [6:0] op);
        fmt = f; imm = im; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; opcode = op;
    endtask

    task automatic push(input logic [2:0] f, input logic [31:0] im, input logic [4:0] d,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [6:0] op);
        int n = 0;
        set_entry(f, im, d, s1, s2, f3, f7, op);
        in_valid = 1'b1;
        #1;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("push_timeout", 32'd0, 32'd1);
        else begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, input string tag);
        int n = 0;
        while (!done && n < max_cyc) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, {31'd0, done}, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = '0; count = '0; in_valid = 1'b0;
        out_ready = 1'b1;
        set_entry(3'd0, 32'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 7'd0);
        #12;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_addr", out_addr, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {24'd0, err_count}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single I-type entry
        outq.delete(); done_cnt = 0;
        do_start(32'h100, 16'd1);
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_in_ready", {31'd0, in_ready}, 32'd1);
        push(3'b000, 32'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 7'h13);
        check("t1_out_valid", {31'd0, out_valid}, 32'd1);
        check("t1_out_instr", out_instr, 32'h00500093);
        check("t1_out_addr", out_addr, 32'h100);
        check("t1_no_early_done", {31'd0, done}, 32'd0);
        wait_done(3, "t1_done");
        check("t1_idle", {31'd0, busy}, 32'd0);
        check("t1_nout", outq.size(), 32'd1);

        // B, J, U back to back with consecutive addresses
        outq.delete(); done_cnt = 0;
        do_start(32'h2000, 16'd3);
        push(3'b010, 32'hFFFF_FFFC, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 7'h63);
        push(3'b100, 32'd8, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 7'h6F);
        push(3'b011, 32'h1234_5000, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 7'h37);
        wait_done(5, "t2_done");
        check("t2_nout", outq.size(), 32'd3);
        if (outq.size() == 3) begin
            check("t2_b_instr", outq[0][31:0], 32'hFE000EE3);
            check("t2_b_addr", outq[0][63:32], 32'h2000);
            check("t2_j_instr", outq[1][31:0], 32'h008000EF);
            check("t2_j_addr", outq[1][63:32], 32'h2004);
            check("t2_u_instr", outq[2][31:0], 32'h123452B7);
            check("t2_u_addr", outq[2][63:32], 32'h2008);
        end
        check("t2_err", {24'd0, err_count}, 32'd0);

        // Two errored entries then one valid entry
        outq.delete(); done_cnt = 0;
        do_start(32'h3000, 16'd3);
        push(3'b000, 32'd2048, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 7'h13);
        push(3'b010, 32'd3, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 7'h63);
        push(3'b000, 32'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 7'h13);
        wait_done(5, "t3_done");
        check("t3_err", {24'd0, err_count}, 32'd2);
        check("t3_nout", outq.size(), 32'd1);
        if (outq.size() == 1) begin
            check("t3_instr", outq[0][31:0], 32'h00500093);
            check("t3_addr", outq[0][63:32], 32'h3000);
        end

        // S, R, illegal format and out-of-range B; err_count restarts at zero
        outq.delete(); done_cnt = 0;
        do_start(32'hFFFF_FFFC, 16'd4);
        check("t4_err_clear", {24'd0, err_count}, 32'd0);
        push(3'b001, 32'd8, 5'd0, 5'd2, 5'd1, 3'd2, 7'd0, 7'h23);
        push(3'b110, 32'd0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 7'h13);
        push(3'b010, 32'd4096, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 7'h63);
        push(3'b101, 32'hDEAD_BEEF, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 7'h33);
        wait_done(5, "t4_done");
        check("t4_err", {24'd0, err_count}, 32'd2);
        check("t4_nout", outq.size(), 32'd2);
        if (outq.size() == 2) begin
            check("t4_s_instr", outq[0][31:0], 32'h00112423);
            check("t4_s_addr", outq[0][63:32], 32'hFFFF_FFFC);
            check("t4_r_instr", outq[1][31:0], 32'h002081B3);
            check("t4_r_addr_wrap", outq[1][63:32], 32'h0000_0000);
        end

        // Output stall for 5 cycles, then no-bubble resume
        outq.delete(); done_cnt = 0;
        do_start(32'h4000, 16'd3);
        out_ready = 1'b0;
        push(3'b000, 32'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 7'h13);
        set_entry(3'b000, 32'd2, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 7'h13);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("t5_stall_valid", {31'd0, out_valid}, 32'd1);
            check("t5_stall_instr", out_instr, 32'h00100093);
            check("t5_stall_addr", out_addr, 32'h4000);
            check("t5_stall_in_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        check("t5_resume_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        check("t5_e2_instr", out_instr, 32'h00200113);
        check("t5_e2_addr", out_addr, 32'h4004);
        set_entry(3'b000, 32'd3, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 7'h13);
        check("t5_e3_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("t5_e3_instr", out_instr, 32'h00300193);
        check("t5_e3_addr", out_addr, 32'h4008);
        wait_done(5, "t5_done");
        check("t5_nout", outq.size(), 32'd3);

        // Empty batch
        outq.delete(); done_cnt = 0; acc_cnt = 0;
        do_start(32'h7000, 16'd0);
        wait_done(2, "t6_done");
        check("t6_nout", outq.size(), 32'd0);
        check("t6_nacc", acc_cnt, 32'd0);

        // Reset mid-batch with a pending output, then a clean restart
        outq.delete(); done_cnt = 0;
        do_start(32'h5000, 16'd2);
        out_ready = 1'b0;
        push(3'b000, 32'd7, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 7'h13);
        check("t7_pending", {31'd0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t7_rst_valid", {31'd0, out_valid}, 32'd0);
        check("t7_rst_busy", {31'd0, busy}, 32'd0);
        check("t7_rst_addr", out_addr, 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t7_no_done", done_cnt, 32'd0);
        do_start(32'h6000, 16'd1);
        check("t7_new_addr", out_addr, 32'h6000);
        push(3'b000, 32'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 7'h13);
        check("t7_new_instr", out_instr, 32'h00500093);
        wait_done(3, "t7_done");
        check("t7_nout", outq.size(), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
